bg_tile_fetcher: RTL and testbench

BG_TILE_FETCHER -- requirements
Module: bg_tile_fetcher

---
 rtl/bg_tile_fetcher_if.sv | 21 ++
 rtl/bg_tile_fetcher.sv | 156 +++++++++++++++
 tb/tb_bg_tile_fetcher.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/bg_tile_fetcher_if.sv
// VRAM read port and background pixel stream of the tile fetcher.
// The fetcher drives the master side; VRAM arbiter and pixel mixer sit on the slave side.
interface bg_tile_fetcher_if;
   logic        vram_rd_req;
   logic [15:0] vram_addr;
   logic        vram_rd_ack;
   logic [7:0]  vram_rd_data;
   logic        pix_valid;
   logic        pix_ready;
   logic [3:0]  bg_pixel;

   modport master (
      output vram_rd_req, vram_addr, pix_valid, bg_pixel,
      input  vram_rd_ack, vram_rd_data, pix_ready
   );

   modport slave (
      input  vram_rd_req, vram_addr, pix_valid, bg_pixel,
      output vram_rd_ack, vram_rd_data, pix_ready
   );
endinterface

// File: rtl/bg_tile_fetcher.sv
// Background tile fetcher: per tile reads nametable, attribute and both pattern planes,
// then streams 8 pixels MSB first while the next tile is fetched.
module bg_tile_fetcher #(
   parameter int NUM_TILES    = 32,
   parameter int PIX_PER_TILE = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              line_start,
   input  logic [8:0]        line_row,
   input  logic [7:0]        ppu_ctrl1,
   output logic [8:0]        req_pixel_row,
   output logic [8:0]        req_pixel_col,
   input  logic [15:0]       nametable_ptr,
   input  logic [2:0]        pattern_table_offset,
   bg_tile_fetcher_if.master bus,
   output logic              line_busy,
   output logic              line_done
);

   typedef enum logic [2:0] {IDLE, NT, AT, PT_LO, PT_HI, WAIT_BUF} state_t;

   typedef struct packed {
      logic [1:0] attr;
      logic [7:0] lo;
      logic [7:0] hi;
   } tile_t;

   localparam logic [4:0] LAST_TILE = 5'(NUM_TILES - 1);
   localparam logic [3:0] FULL_CNT  = 4'(PIX_PER_TILE);

   state_t      state, state_nxt;
   tile_t       staging, shifter;
   logic [7:0]  tile_id;
   logic [4:0]  tile_idx;
   logic [3:0]  shift_cnt;
   logic        last_loaded;
   logic        accept, xfer, pix_take, last_tile;
   logic [2:0]  attr_shift;
   logic [15:0] pt_addr;
   logic        unused_ctrl;

   assign unused_ctrl = &{1'b0, ppu_ctrl1[7:5], ppu_ctrl1[3:0]};

   // A new line waits until the previous line's last pixels have drained.
   assign accept     = (state == IDLE) && line_start && !line_busy;
   assign pix_take   = bus.pix_valid && bus.pix_ready;
   assign xfer       = (state == WAIT_BUF) &&
                       ((shift_cnt == 4'd0) || ((shift_cnt == 4'd1) && bus.pix_ready));
   assign last_tile  = (tile_idx == LAST_TILE);
   assign attr_shift = {nametable_ptr[6], nametable_ptr[1], 1'b0};
   assign pt_addr    = {3'b000, ppu_ctrl1[4], tile_id, 1'b0, pattern_table_offset};

   assign bus.pix_valid = (shift_cnt != 4'd0);
   assign bus.bg_pixel  = {shifter.attr, shifter.hi[7], shifter.lo[7]};
   assign req_pixel_col = {1'b0, tile_idx, 3'b000};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      // NOTE: default assignment first so every path drives state_nxt; otherwise a latch is inferred.
      state_nxt = state;
      unique case (state)
         IDLE:     if (accept)          state_nxt = NT;
         NT:       if (bus.vram_rd_ack) state_nxt = AT;
         AT:       if (bus.vram_rd_ack) state_nxt = PT_LO;
         PT_LO:    if (bus.vram_rd_ack) state_nxt = PT_HI;
         PT_HI:    if (bus.vram_rd_ack) state_nxt = WAIT_BUF;
         WAIT_BUF: if (xfer)            state_nxt = last_tile ? IDLE : NT;
         default:                       state_nxt = IDLE;
      endcase
   end

   // Addresses are built from registered or generator-held inputs, so they stay put until ack.
   always_comb begin
      bus.vram_rd_req = 1'b0;
      bus.vram_addr   = 16'h0000;
      case (state)
         NT: begin
            bus.vram_rd_req = 1'b1;
            bus.vram_addr   = nametable_ptr;
         end
         AT: begin
            bus.vram_rd_req = 1'b1;
            bus.vram_addr   = 16'h23C0 | (nametable_ptr & 16'h0C00) |
                              ((nametable_ptr >> 4) & 16'h0038) |
                              ((nametable_ptr >> 2) & 16'h0007);
         end
         PT_LO: begin
            bus.vram_rd_req = 1'b1;
            bus.vram_addr   = pt_addr;
         end
         PT_HI: begin
            bus.vram_rd_req = 1'b1;
            bus.vram_addr   = pt_addr | 16'h0008;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_pixel_row <= '0;
         tile_idx      <= '0;
         tile_id       <= '0;
         staging       <= '0;
         shifter       <= '0;
         shift_cnt     <= '0;
         last_loaded   <= 1'b0;
         line_busy     <= 1'b0;
         line_done     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every register here samples pre-edge values.
         line_done <= 1'b0;

         if (accept) begin
            req_pixel_row <= line_row;
            tile_idx      <= '0;
            line_busy     <= 1'b1;
            last_loaded   <= 1'b0;
         end

         if (bus.vram_rd_ack) begin
            case (state)
               NT:      tile_id      <= bus.vram_rd_data;
               AT:      staging.attr <= 2'(bus.vram_rd_data >> attr_shift);
               PT_LO:   staging.lo   <= bus.vram_rd_data;
               PT_HI:   staging.hi   <= bus.vram_rd_data;
               default: ;
            endcase
         end

         if (xfer) begin
            shifter   <= staging;
            shift_cnt <= FULL_CNT;
            if (last_tile) last_loaded <= 1'b1;
            else           tile_idx    <= tile_idx + 5'd1;
         end else if (pix_take) begin
            shifter.lo <= {shifter.lo[6:0], 1'b0};
            shifter.hi <= {shifter.hi[6:0], 1'b0};
            shift_cnt  <= shift_cnt - 4'd1;
         end

         // Final pixel of the last tile leaves: close the line in the same edge.
         if (pix_take && (shift_cnt == 4'd1) && last_loaded) begin
            line_done   <= 1'b1;
            line_busy   <= 1'b0;
            last_loaded <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bg_tile_fetcher.sv
// Directed bench for bg_tile_fetcher: a tile table feeds both the address-generator model and
// the VRAM responder, and every read address and pixel is compared against hand-computed values.
`timescale 1ns/1ps
module tb_bg_tile_fetcher;

   localparam int NV          = 5;
   localparam int LINE_BUDGET = 2000;
   localparam int NPIX        = 256;
   localparam int NREADS      = 128;

   typedef struct {
      logic [15:0] ptr;
      logic [2:0]  off;
      logic        pt_sel;
      logic [7:0]  tile_id;
      logic [7:0]  at_byte;
      logic [7:0]  lo;
      logic [7:0]  hi;
      logic [15:0] at_addr;
      logic [15:0] pt_addr;
      logic [31:0] pix;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        line_start;
   logic [8:0]  line_row;
   logic [7:0]  ppu_ctrl1;
   logic [8:0]  req_pixel_row;
   logic [8:0]  req_pixel_col;
   logic [15:0] nametable_ptr;
   logic [2:0]  pattern_table_offset;
   logic        line_busy;
   logic        line_done;

   bg_tile_fetcher_if bus();

   vec_t vecs[NV];
   int   gen_idx;
   int   tests = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   // Address-generator model: tile k of the line uses table entry k mod NV.
   assign gen_idx              = int'(req_pixel_col[7:3]) % NV;
   assign nametable_ptr        = vecs[gen_idx].ptr;
   assign pattern_table_offset = vecs[gen_idx].off;
   assign ppu_ctrl1            = {3'b101, vecs[gen_idx].pt_sel, 4'b1010};

   bg_tile_fetcher #(.NUM_TILES(32), .PIX_PER_TILE(8)) dut (
      .clk                  (clk),
      .rst_n                (rst_n),
      .line_start           (line_start),
      .line_row             (line_row),
      .ppu_ctrl1            (ppu_ctrl1),
      .req_pixel_row        (req_pixel_row),
      .req_pixel_col        (req_pixel_col),
      .nametable_ptr        (nametable_ptr),
      .pattern_table_offset (pattern_table_offset),
      .bus                  (bus),
      .line_busy            (line_busy),
      .line_done            (line_done)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_vram_rd_req"},   bus.vram_rd_req,  0);
      check({tag, "_vram_addr"},     bus.vram_addr,    0);
      check({tag, "_pix_valid"},     bus.pix_valid,    0);
      check({tag, "_bg_pixel"},      bus.bg_pixel,     0);
      check({tag, "_line_busy"},     line_busy,        0);
      check({tag, "_line_done"},     line_done,        0);
      check({tag, "_req_pixel_row"}, req_pixel_row,    0);
      check({tag, "_req_pixel_col"}, req_pixel_col,    0);
   endtask

   // Runs one scanline from a negedge. delay: idle cycles before each ack; stall_at: first of
   // 10 cycles with pix_ready low; ignore_at: cycle of a line_start that must be ignored;
   // abort_rd: return when that read is first requested; late_ack: ack high on the first edge.
   task automatic run_line(input logic [8:0] row, input int delay, input int stall_at,
                           input int ignore_at, input int abort_rd, input bit late_ack);
      int          rd_no;
      int          pix_no;
      int          wcnt;
      int          dones;
      bit          ghost;
      vec_t        v;
      logic [15:0] exp_addr;
      logic [3:0]  exp_pix;
      rd_no  = 0;
      pix_no = 0;
      wcnt   = 0;
      dones  = 0;
      ghost  = late_ack;
      line_row          = row;
      line_start        = 1'b1;
      bus.pix_ready     = 1'b1;
      bus.vram_rd_ack   = late_ack;
      bus.vram_rd_data  = 8'hFF;
      for (int cyc = 0; cyc < LINE_BUDGET && dones == 0; cyc++) begin
         @(posedge clk);
         @(negedge clk);
         line_start = (cyc == ignore_at);
         if (cyc == ignore_at) line_row = row ^ 9'h1FF;

         if (bus.vram_rd_ack) begin
            bus.vram_rd_ack = 1'b0;
            if (ghost) ghost = 1'b0;
            else begin
               rd_no++;
               wcnt = 0;
            end
         end
         if (abort_rd >= 0 && rd_no == abort_rd && bus.vram_rd_req) return;

         if (wcnt > 0) check("vram_req_held", bus.vram_rd_req, 1);
         if (bus.vram_rd_req) begin
            v = vecs[(rd_no / 4) % NV];
            case (rd_no % 4)
               0:       exp_addr = v.ptr;
               1:       exp_addr = v.at_addr;
               2:       exp_addr = v.pt_addr;
               default: exp_addr = v.pt_addr + 16'h0008;
            endcase
            check("vram_addr", bus.vram_addr, exp_addr);
            check("req_pixel_col", req_pixel_col, 32'((rd_no / 4) * 8));
            check("req_pixel_row", req_pixel_row, row);
            check("line_busy", line_busy, 1);
            if (wcnt >= delay) begin
               bus.vram_rd_ack = 1'b1;
               case (rd_no % 4)
                  0:       bus.vram_rd_data = v.tile_id;
                  1:       bus.vram_rd_data = v.at_byte;
                  2:       bus.vram_rd_data = v.lo;
                  default: bus.vram_rd_data = v.hi;
               endcase
            end else begin
               wcnt++;
            end
         end

         bus.pix_ready = !(stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 10);
         if (bus.pix_valid) begin
            v       = vecs[(pix_no / 8) % NV];
            exp_pix = v.pix[4 * (7 - pix_no % 8) +: 4];
            check("bg_pixel", bus.bg_pixel, exp_pix);
            if (bus.pix_ready) pix_no++;
         end
         if (stall_at >= 0 && cyc == stall_at + 9)
            check("stall_in_wait_buf", bus.vram_rd_req, 0);

         if (line_done) begin
            dones++;
            check("line_busy_at_done", line_busy, 0);
            check("pixels_at_done", pix_no, NPIX);
         end
      end
      check("line_done_pulses", dones, 1);
      check("vram_reads", rd_no, NREADS);
      repeat (3) begin
         @(negedge clk);
         check("no_extra_done", line_done, 0);
         check("idle_line_busy", line_busy, 0);
         check("idle_pix_valid", bus.pix_valid, 0);
      end
   endtask

   initial begin
      // ptr, off, pt_sel, tile_id, at_byte, lo, hi, AT addr, PT_LO addr, 8 pixels (first in MSB nibble)
      vecs[0] = '{16'h2000, 3'd3, 1'b1, 8'h42, 8'hE4, 8'hF0, 8'h0F, 16'h23C0, 16'h1423, 32'h1111_2222};
      // (ptr>>4)&0x38 and (ptr>>2)&7 are both zero here; attribute shift 6 selects 3
      vecs[1] = '{16'h2C63, 3'd5, 1'b0, 8'hA5, 8'hE4, 8'hAA, 8'hCC, 16'h2FC0, 16'h0A55, 32'hFEDC_FEDC};
      vecs[2] = '{16'h2042, 3'd7, 1'b1, 8'hFF, 8'hE4, 8'h81, 8'h7E, 16'h23C0, 16'h1FF7, 32'hDEEE_EEED};
      vecs[3] = '{16'h2B9E, 3'd0, 1'b0, 8'h00, 8'h1B, 8'h0F, 8'h33, 16'h2BFF, 16'h0000, 32'h88AA_99BB};
      vecs[4] = '{16'h2002, 3'd1, 1'b1, 8'h10, 8'hE4, 8'h00, 8'hFF, 16'h23C0, 16'h1101, 32'h6666_6666};

      rst_n            = 1'b0;
      line_start       = 1'b0;
      line_row         = '0;
      bus.vram_rd_ack  = 1'b0;
      bus.vram_rd_data = '0;
      bus.pix_ready    = 1'b1;
      repeat (3) @(negedge clk);
      check_reset("por");
      rst_n = 1'b1;

      run_line(9'd37,  0, -1, -1, -1, 1'b0);
      run_line(9'd0,   0, 20,  6, -1, 1'b0);
      run_line(9'd200, 5, -1, 30, -1, 1'b0);

      // Abandon a line in the middle of tile 1's PT_LO read while tile 0 is shifting out.
      run_line(9'd100, 1, -1, -1, 6, 1'b0);
      check("mid_line_pix_valid", bus.pix_valid, 1);
      check("mid_line_req_col", req_pixel_col, 8);
      #2 rst_n = 1'b0;
      #1 check_reset("async");
      bus.vram_rd_ack  = 1'b1;
      bus.vram_rd_data = 8'hFF;
      @(posedge clk);
      @(negedge clk);
      check_reset("held");
      rst_n = 1'b1;
      run_line(9'h1FF, 2, -1, -1, -1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
